// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control unit.
// Moore FSM sequencing fetch, decode, execute, memory and writeback.
module multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ANDIEX = 4'd11,
    S_IMMWB  = 4'd12
  } st_e;

  st_e state_q;
  st_e state_d;

  logic is_lw;
  logic is_sw;
  logic is_rt;
  logic is_beq;
  logic is_j;
  logic is_addi;
  logic is_andi;

  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_rt   = (op == 6'b000000);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_addi = (op == 6'b001000);
  assign is_andi = (op == 6'b001100);

  assign state = state_q;

  // State register; reset forces FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state and output decode; everything is held low during reset.
  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          unique case (1'b1)
            is_lw, is_sw: state_d = S_MEMADR;
            is_rt:        state_d = S_EXEC;
            is_beq:       state_d = S_BRANCH;
            is_j:         state_d = S_JUMP;
            is_addi:      state_d = S_ADDIEX;
            is_andi:      state_d = S_ANDIEX;
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = is_lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_RWB;
        end
        S_RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_IMMWB;
        end
        S_ANDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
          state_d = S_IMMWB;
        end
        S_IMMWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Stimulus queues expected output words; a monitor compares them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic       instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  // control word: PCW PCWC IorD MR MW MtR IRW RW RD ASA ID IL | PCS ASB AOP
  localparam logic [17:0] C_RST  = {12'b000000000000, 6'b000000};
  localparam logic [17:0] C_FW   = {12'b000100000000, 6'b000100};
  localparam logic [17:0] C_FR   = {12'b100100100000, 6'b000100};
  localparam logic [17:0] C_DEC  = {12'b000000000000, 6'b001100};
  localparam logic [17:0] C_ILL  = {12'b000000000001, 6'b001100};
  localparam logic [17:0] C_MADR = {12'b000000000100, 6'b001000};
  localparam logic [17:0] C_MRD  = {12'b001100000000, 6'b000000};
  localparam logic [17:0] C_MWB  = {12'b000001010010, 6'b000000};
  localparam logic [17:0] C_MWRW = {12'b001010000000, 6'b000000};
  localparam logic [17:0] C_MWRR = {12'b001010000010, 6'b000000};
  localparam logic [17:0] C_EXEC = {12'b000000000100, 6'b000010};
  localparam logic [17:0] C_RWB  = {12'b000000011010, 6'b000000};
  localparam logic [17:0] C_BR   = {12'b010000000110, 6'b010001};
  localparam logic [17:0] C_JMP  = {12'b100000000010, 6'b100000};
  localparam logic [17:0] C_ADDI = {12'b000000000100, 6'b001000};
  localparam logic [17:0] C_ANDI = {12'b000000000100, 6'b001011};
  localparam logic [17:0] C_IWB  = {12'b000000010010, 6'b000000};

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .instr_done(instr_done), .illegal_op(illegal_op),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] act;
  assign act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
                instr_done, illegal_op, PCSource, ALUSrcB, ALUOp};

  // Monitor: compare mid-cycle, and right after an async reset drop.
  initial begin
    logic [21:0] e;
    string n;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                   n, act[21:18], act[17:0], e[21:18], e[17:0]);
        end
      end
    end
  end

  task automatic drive(input logic [5:0] o, input logic mr,
                       input logic [3:0] s, input logic [17:0] c,
                       input string n);
    op = o;
    mem_ready = mr;
    exp_q.push_back({s, c});
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    drive(6'd0, 1'b1, 4'd0, C_RST, "reset_async");
    reset_n = 1'b0;
    tick();
    drive(6'd0, 1'b1, 4'd0, C_RST, "reset_hold");
    tick();
    reset_n = 1'b1;
    // R-type
    drive(6'b000000, 1'b1, 4'd0, C_FR,   "r_fetch");  tick();
    drive(6'b000000, 1'b1, 4'd1, C_DEC,  "r_decode"); tick();
    drive(6'b101011, 1'b1, 4'd6, C_EXEC, "r_exec");   tick();
    drive(6'b100011, 1'b1, 4'd7, C_RWB,  "r_rwb");    tick();
    // lw with two MEMRD wait cycles
    drive(6'b111111, 1'b1, 4'd0, C_FR,   "lw_fetch");  tick();
    drive(6'b100011, 1'b1, 4'd1, C_DEC,  "lw_decode"); tick();
    drive(6'b100011, 1'b1, 4'd2, C_MADR, "lw_memadr"); tick();
    drive(6'b000000, 1'b0, 4'd3, C_MRD,  "lw_memrd0"); tick();
    drive(6'b000100, 1'b0, 4'd3, C_MRD,  "lw_memrd1"); tick();
    drive(6'b000010, 1'b1, 4'd3, C_MRD,  "lw_memrd2"); tick();
    drive(6'b000000, 1'b1, 4'd4, C_MWB,  "lw_memwb");  tick();
    // sw with three FETCH wait cycles
    drive(6'b000000, 1'b0, 4'd0, C_FW,   "sw_fwait0"); tick();
    drive(6'b000010, 1'b0, 4'd0, C_FW,   "sw_fwait1"); tick();
    drive(6'b100011, 1'b0, 4'd0, C_FW,   "sw_fwait2"); tick();
    drive(6'b101011, 1'b1, 4'd0, C_FR,   "sw_fetch");  tick();
    drive(6'b101011, 1'b1, 4'd1, C_DEC,  "sw_decode"); tick();
    drive(6'b101011, 1'b1, 4'd2, C_MADR, "sw_memadr"); tick();
    drive(6'b100011, 1'b0, 4'd5, C_MWRW, "sw_wrwait"); tick();
    drive(6'b100011, 1'b1, 4'd5, C_MWRR, "sw_wrdone"); tick();
    // beq then j
    drive(6'b000100, 1'b1, 4'd0, C_FR,   "beq_fetch");  tick();
    drive(6'b000100, 1'b1, 4'd1, C_DEC,  "beq_decode"); tick();
    drive(6'b000000, 1'b1, 4'd8, C_BR,   "beq_branch"); tick();
    drive(6'b000010, 1'b1, 4'd0, C_FR,   "j_fetch");    tick();
    drive(6'b000010, 1'b1, 4'd1, C_DEC,  "j_decode");   tick();
    drive(6'b000000, 1'b1, 4'd9, C_JMP,  "j_jump");     tick();
    // andi then addi
    drive(6'b001100, 1'b1, 4'd0,  C_FR,   "andi_fetch");  tick();
    drive(6'b001100, 1'b1, 4'd1,  C_DEC,  "andi_decode"); tick();
    drive(6'b001000, 1'b1, 4'd11, C_ANDI, "andi_ex");     tick();
    drive(6'b001000, 1'b1, 4'd12, C_IWB,  "andi_wb");     tick();
    drive(6'b001000, 1'b1, 4'd0,  C_FR,   "addi_fetch");  tick();
    drive(6'b001000, 1'b1, 4'd1,  C_DEC,  "addi_decode"); tick();
    drive(6'b001100, 1'b1, 4'd10, C_ADDI, "addi_ex");     tick();
    drive(6'b001100, 1'b1, 4'd12, C_IWB,  "addi_wb");     tick();
    // illegal opcode
    drive(6'b111111, 1'b1, 4'd0, C_FR,   "ill_fetch");  tick();
    drive(6'b111111, 1'b1, 4'd1, C_ILL,  "ill_decode"); tick();
    drive(6'b101011, 1'b1, 4'd0, C_FR,   "ill_refetch"); tick();
    // sw interrupted by async reset in MEMWR
    drive(6'b101011, 1'b1, 4'd1, C_DEC,  "rst_decode"); tick();
    drive(6'b101011, 1'b1, 4'd2, C_MADR, "rst_memadr"); tick();
    drive(6'b101011, 1'b0, 4'd5, C_MWRW, "rst_memwr");
    #6;
    drive(6'b101011, 1'b1, 4'd0, C_RST, "rst_mid_instr");
    reset_n = 1'b0;
    tick();
    drive(6'b101011, 1'b1, 4'd0, C_RST, "rst_mid_hold");
    tick();
    reset_n = 1'b1;
    // recovery: R-type runs normally after reset
    drive(6'b000000, 1'b1, 4'd0, C_FR,   "rec_fetch");  tick();
    drive(6'b000000, 1'b1, 4'd1, C_DEC,  "rec_decode"); tick();
    drive(6'b000000, 1'b1, 4'd6, C_EXEC, "rec_exec");   tick();
    drive(6'b000000, 1'b1, 4'd7, C_RWB,  "rec_rwb");    tick();
    drive(6'b000000, 1'b0, 4'd0, C_FW,   "rec_fwait");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected words never compared, expected 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low: clk (input, 1) and reset_n (input, 1), listed first.
REQ-002 The block SHALL provide these further inputs: op (6 bits, instruction opcode from IR) and mem_ready (1 bit, memory access complete this cycle).
REQ-003 The block SHALL provide these 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op.
REQ-004 The block SHALL provide these 2-bit outputs: PCSource, ALUSrcB, ALUOp (to the ALU control stage: 00 add, 01 sub, 10 funct-decoded, 11 and).
REQ-005 The block SHALL provide state (output, 4 bits), the current state encoding, for debug.

Function
REQ-006 The block SHALL be a Moore FSM with one state register of 4 bits; outputs SHALL be decoded from state, plus the mem_ready and op qualifiers named below; any output not listed for a state SHALL be 0.
REQ-007 The encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ANDIEX 11, IMMWB 12.
REQ-008 FETCH SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-009 FETCH SHALL assert PCWrite and IRWrite only when mem_ready=1.
REQ-010 FETCH SHALL remain in FETCH while mem_ready=0, and go to DECODE when mem_ready=1.
REQ-011 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-012 DECODE next state by op SHALL be: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; 001100 -> ANDIEX.
REQ-013 DECODE with any other op SHALL go to FETCH and assert illegal_op for that one cycle.
REQ-014 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEMRD if op=100011, else MEMWR.
REQ-015 MEMRD SHALL assert MemRead=1, IorD=1; it SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-016 MEMWB SHALL assert RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; next state SHALL be FETCH.
REQ-017 MEMWR SHALL assert MemWrite=1, IorD=1; it SHALL hold while mem_ready=0.
REQ-018 When mem_ready=1, MEMWR SHALL assert instr_done and go to FETCH.
REQ-019 EXEC SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state SHALL be RWB.
REQ-020 RWB SHALL assert RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1; next state SHALL be FETCH.
REQ-021 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next state SHALL be FETCH.
REQ-022 JUMP SHALL assert PCWrite=1, PCSource=10, instr_done=1; next state SHALL be FETCH.
REQ-023 ADDIEX SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be IMMWB.
REQ-024 ANDIEX SHALL be identical to ADDIEX except ALUOp=11.
REQ-025 IMMWB SHALL assert RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1; next state SHALL be FETCH.
REQ-026 Unused encodings 13-15 SHALL drive all outputs to 0 and go to FETCH on the next clock.
REQ-027 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-028 Latency SHALL be: R-type 4, beq/j 3, addi/andi 4, lw 5, sw 4 cycles, with each mem_ready wait cycle adding 1.

Reset
REQ-029 reset_n=0 SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-030 While reset_n=0, all outputs except state SHALL be held at 0.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction with no write strobe asserted.
REQ-032 After reset_n rises, the first active clock edge SHALL evaluate FETCH normally.

Verification
REQ-033 Scenario: reset, mem_ready=1, op=000000 -> states 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1, RegDst=1 in state 7; instr_done pulses once.
REQ-034 Scenario: op=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-035 Scenario: op=101011 with mem_ready=0 in FETCH for 3 cycles -> PCWrite=0 and IRWrite=0 while waiting; MemWrite=1, IorD=1 in MEMWR; instr_done=1 only on the mem_ready cycle.
REQ-036 Scenario: op=000100 then op=000010 -> BRANCH gives ALUOp=01, PCWriteCond=1, PCSource=01; JUMP gives PCWrite=1, PCSource=10.
REQ-037 Scenario: op=001100 -> ANDIEX gives ALUOp=11; op=001000 -> ADDIEX gives ALUOp=00; both then IMMWB with RegWrite=1.
REQ-038 Scenario: op=111111 -> illegal_op=1 in DECODE only, then FETCH; reset_n pulled low asynchronously in MEMWR -> state=0 and MemWrite=0 before the next clk edge.
